mult_share_sched: RTL
=====================

# mult_share_sched

Round-robin scheduler that shares one iterative shift-add multiplier between two requesters. It sits between two independent producers of unsigned multiply operands and a single result consumer. It accepts one operation at a time and runs it to completion over a fixed WIDTH cycles. It returns the full double-width product tagged with the id of the requester that issued it.

## Interface
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits; must be >= 2
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation is accepted this cycle
- req0_a, req0_b  in  WIDTH each  requester 0 unsigned operands
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result this cycle
- rsp_id  out  1  requester that issued the result (0 or 1)
- rsp_p  out  2*WIDTH  unsigned product a*b
- busy  out  1  high in RUN or DONE

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE:
  - Grant goes to requester 0 or 1 when its valid is high.
  - If both are valid, the grant goes to the requester other than last_grant.
  - reqN_ready = (state==IDLE) & reqN_valid & granted. It is combinational and at most one ready is high.
- Transfer occurs when reqN_valid & reqN_ready on a rising edge. At that edge:
  - capture mcand = a, zero-extended to 2*WIDTH
  - capture mplier = b
  - acc = 0, cnt = 0, id = N, last_grant = N
  - go to RUN
- RUN, each edge:
  - if mplier[0], acc += mcand, modulo 2^(2*WIDTH), which never overflows
  - mcand <<= 1, mplier >>= 1, cnt += 1
  - on the edge where cnt reaches WIDTH: load rsp_p with the final acc and rsp_id with id, and go to DONE
- RUN always takes exactly WIDTH iterations. There is no early termination for zero or small operands.
- Requester readies are 0 in RUN and DONE. Input operands are ignored after the accepting edge, so requesters may change them freely.
- DONE:
  - rsp_valid = 1; rsp_p and rsp_id are held stable
  - on an edge with rsp_ready = 1, go to IDLE
  - no request is accepted in the same cycle the response is taken
- A requester that drops valid before being readied simply loses its turn. It is never granted retroactively.
- Reset, asynchronous, at any time including mid-RUN or in DONE:
  - state = IDLE, last_grant = 1 (requester 0 wins the first contention)
  - rsp_valid = 0, rsp_p = 0, rsp_id = 0, busy = 0
  - the in-flight operation is discarded
  - readies follow IDLE rules immediately after rst_n rises

## Timing
- Accepting edge = E0. RUN iterations occur on edges E1..EWIDTH.
- rsp_valid is high starting in the cycle after edge EWIDTH, i.e. WIDTH cycles after acceptance.
- Earliest next accept is one cycle after the response handshake.
- Minimum issue interval is WIDTH+2 cycles.
- rsp_valid, rsp_p, rsp_id and busy are registered.
- req0_ready and req1_ready are combinational from state, valids and last_grant.
- rsp_valid stays high with unchanged data for as long as rsp_ready is low. There is no timeout.
- rsp_p keeps its last value in IDLE and RUN until the next completion or reset.

## Test plan
- WIDTH=16, req0 a=3 b=5 alone: req0_ready high same cycle; rsp_valid exactly 16 cycles after accept; rsp_p=15, rsp_id=0.
- Max operands, req1 a=0xFFFF b=0xFFFF: rsp_p=0xFFFE0001, rsp_id=1.
- Zero operand a=0 b=0x1234: latency is still 16 cycles; rsp_p=0.
- Both valid continuously, rsp_ready=1, after reset: accept order is 0,1,0,1; each grant alternates; readies are never both high.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid with req1_valid high. rsp_p and rsp_id are stable, req1_ready stays 0. After the rsp handshake, req1 is accepted on the following cycle.
- Reset at cycle 8 of RUN: all outputs go to their reset values asynchronously. A following simultaneous req0/req1 gives the first grant to req0, with a correct product.

Source files
------------

// File: rtl/mult_share_sched_if.sv
// Request/response bundle for the shared multiplier: two operand requesters and one result consumer.
// master = producer/consumer side, slave = scheduler side.
interface mult_share_sched_if #(
    parameter int WIDTH = 16
);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_p;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one WIDTH-cycle shift-add multiplier between two requesters.
// Each accepted operation returns its full 2*WIDTH-bit product tagged with the requester id.
module mult_share_sched #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_share_sched_if.slave   bus,
    output logic                busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic               last_grant;
    logic               grant1;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               id;
    logic               rsp_valid;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_p;

    // On contention the requester that was not served last time wins.
    always_comb begin
        grant1 = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant1 = ~last_grant;
        end
    end

    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant1;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid && grant1;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_p      = rsp_p;

    assign acc_sum = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            id         <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_p      <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0_ready || bus.req1_ready) begin
                        mcand      <= {{WIDTH{1'b0}}, (grant1 ? bus.req1_a : bus.req0_a)};
                        mplier     <= grant1 ? bus.req1_b : bus.req0_b;
                        acc        <= '0;
                        cnt        <= '0;
                        id         <= grant1;
                        last_grant <= grant1;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Always a fixed WIDTH iterations, even for zero or small operands.
                    if (cnt == LAST) begin
                        rsp_p     <= acc_sum;
                        rsp_id    <= id;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
